// File: rtl/delay_hold.sv
// Off-delay (hold) stretcher: 'out' rises one cycle after 'in' and stays high for a
// fixed hold time after 'in' falls, unless 'in' returns or 'flush' ends the hold early.
module delay_hold #(
    parameter logic INIT           = 1'b0,
    parameter int   NBITS          = 4,
    parameter int   CMP_NUM_MSBITS = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic in,
    input  logic flush,
    output logic out,
    output logic holding,
    output logic expired
);

    localparam int CMP = (CMP_NUM_MSBITS < NBITS) ? CMP_NUM_MSBITS : NBITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam state_t RESET_STATE = INIT ? ON : IDLE;

    // Power-up values match the reset values, so the block is sane even before RST.
    state_t           state     = RESET_STATE;
    logic [NBITS-1:0] count     = '0;
    logic             out_q     = INIT;
    logic             holding_q = 1'b0;
    logic             expired_q = 1'b0;

    // Only the top CMP bits decide expiry; checked before incrementing, so no wrap.
    logic expire_now;
    assign expire_now = &count[NBITS-1 -: CMP];

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RESET_STATE;
            out_q     <= INIT;
            holding_q <= 1'b0;
            expired_q <= 1'b0;
            count     <= '0;
        end else begin
            expired_q <= 1'b0;
            if (in) begin
                state     <= ON;
                out_q     <= 1'b1;
                holding_q <= 1'b0;
                count     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ON: begin
                        if (flush) begin
                            state     <= IDLE;
                            out_q     <= 1'b0;
                            expired_q <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            holding_q <= 1'b1;
                            count     <= '0;
                        end
                    end
                    HOLD: begin
                        if (flush || expire_now) begin
                            state     <= IDLE;
                            out_q     <= 1'b0;
                            holding_q <= 1'b0;
                            expired_q <= 1'b1;
                            count     <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_q     <= 1'b0;
                        holding_q <= 1'b0;
                        count     <= '0;
                    end
                endcase
            end
        end
    end

    assign out     = out_q;
    assign holding = holding_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_delay_hold.sv
// Drives three delay_hold configurations with shared directed and random stimulus and
// compares each against a hold-length model derived from the expected hold duration.
module tb_delay_hold;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_s = 1'b0;
    logic flush = 1'b0;

    logic [2:0] d_out, d_hold, d_exp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: NBITS=4 CMP=4 INIT=0   1: NBITS=4 CMP=4 INIT=1   2: NBITS=6 CMP=2 INIT=0
    delay_hold #(.INIT(1'b0), .NBITS(4), .CMP_NUM_MSBITS(4)) u0 (
        .CLK(clk), .RST(rst), .in(in_s), .flush(flush),
        .out(d_out[0]), .holding(d_hold[0]), .expired(d_exp[0]));
    delay_hold #(.INIT(1'b1), .NBITS(4), .CMP_NUM_MSBITS(4)) u1 (
        .CLK(clk), .RST(rst), .in(in_s), .flush(flush),
        .out(d_out[1]), .holding(d_hold[1]), .expired(d_exp[1]));
    delay_hold #(.INIT(1'b0), .NBITS(6), .CMP_NUM_MSBITS(2)) u2 (
        .CLK(clk), .RST(rst), .in(in_s), .flush(flush),
        .out(d_out[2]), .holding(d_hold[2]), .expired(d_exp[2]));

    // Hold lengths in cycles, from edge entering HOLD to edge where out falls.
    int  hold_len [3] = '{16, 16, 49};
    bit  init_v   [3] = '{1'b0, 1'b1, 1'b0};

    bit m_out [3];
    bit m_hold[3];
    bit m_exp [3];
    int m_age [3];
    int max_age_seen = 0;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic void model_step(input int k, input bit r, input bit i, input bit f);
        m_exp[k] = 1'b0;
        if (r) begin
            m_out[k] = init_v[k]; m_hold[k] = 1'b0; m_age[k] = 0;
        end else if (i) begin
            m_out[k] = 1'b1; m_hold[k] = 1'b0; m_age[k] = 0;
        end else if (!m_out[k]) begin
            m_age[k] = 0;
        end else if (f) begin
            m_out[k] = 1'b0; m_hold[k] = 1'b0; m_exp[k] = 1'b1; m_age[k] = 0;
        end else if (!m_hold[k]) begin
            m_hold[k] = 1'b1; m_age[k] = 0;
        end else if (m_age[k] + 1 == hold_len[k]) begin
            m_out[k] = 1'b0; m_hold[k] = 1'b0; m_exp[k] = 1'b1; m_age[k] = 0;
        end else begin
            m_age[k]++;
            if (k == 2 && m_age[k] > max_age_seen) max_age_seen = m_age[k];
        end
    endfunction

    // Drive inputs away from the edge, clock once, then compare all instances.
    task automatic cycle(input bit r, input bit i, input bit f);
        rst = r; in_s = i; flush = f;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, i, f);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.out", k), d_out[k], m_out[k]);
            check($sformatf("u%0d.holding", k), d_hold[k], m_hold[k]);
            check($sformatf("u%0d.expired", k), d_exp[k], m_exp[k]);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit r, input bit i, input bit f);
        for (int c = 0; c < n; c++) cycle(r, i, f);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_out[k] = init_v[k]; m_hold[k] = 1'b0; m_exp[k] = 1'b0; m_age[k] = 0;
        end
        @(negedge clk);
        run(2, 1, 0, 0);
        run(20, 0, 0, 0);     // idle (u1 starts ON and runs its own hold here)
        run(5, 0, 1, 0);
        run(20, 0, 0, 0);     // full 16-cycle hold
        run(5, 0, 1, 0);
        run(8, 0, 0, 0);
        run(1, 0, 1, 0);      // cancel mid-hold
        run(20, 0, 0, 0);
        run(3, 0, 1, 0);
        run(3, 0, 0, 0);
        run(1, 0, 0, 1);      // flush during hold
        run(3, 0, 0, 1);      // flush while idle: no pulse
        run(2, 0, 1, 1);      // flush ignored while in=1
        run(1, 0, 0, 1);      // flush straight from ON
        run(2, 0, 1, 0);
        run(1, 0, 1, 0);
        run(5, 0, 0, 0);
        run(1, 1, 0, 0);      // reset during hold
        run(20, 0, 0, 0);
        run(3, 0, 1, 0);
        run(1, 0, 0, 0);
        run(1, 0, 1, 0);      // 1-cycle glitch while ON
        run(60, 0, 0, 0);     // long hold for the 49-cycle instance
        // Random segments of level runs with occasional flush/reset.
        for (int s = 0; s < 150; s++) begin
            bit lvl;
            int len;
            lvl = ($urandom_range(0, 1) == 1);
            len = $urandom_range(1, 60);
            for (int c = 0; c < len; c++) begin
                cycle(($urandom_range(0, 299) == 0),
                      lvl,
                      ($urandom_range(0, 39) == 0));
            end
        end
        check("u2.max_count_reached", (max_age_seen == 48), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
